fir_mac_controller: RTL

//  Sequencing FSM for the serial-MAC FIR datapath (shift register, coefficient memory,

---
 rtl/fir_mac_controller_if.sv | 22 ++
 rtl/fir_mac_controller.sv | 70 +++++++
 2 files changed

// File: rtl/fir_mac_controller_if.sv
// Sample-in / result-out handshake between the FIR controller and its source/sink.
// master: the controller side; slave: the UART source/sink side.
interface fir_mac_controller_if;
   logic in_valid;
   logic in_ready;
   logic out_valid;
   logic out_ready;

   modport master (
      input  in_valid,
      input  out_ready,
      output in_ready,
      output out_valid
   );

   modport slave (
      output in_valid,
      output out_ready,
      input  in_ready,
      input  out_valid
   );
endinterface

// File: rtl/fir_mac_controller.sv
// Sequencing FSM for a serial-MAC FIR datapath: accept a sample, run LENGTH
// accumulate cycles over the taps, then hold the result until the sink takes it.
module fir_mac_controller #(
   parameter int unsigned LENGTH      = 64,
   parameter int unsigned COUNTER_BIT = 5
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   fir_mac_controller_if.master   bus,
   output logic [COUNTER_BIT:0]   o_cnt,
   output logic                   o_shift_en,
   output logic                   o_resreg_en,
   output logic                   o_flush,
   output logic                   o_busy
);

   localparam int unsigned CntW = COUNTER_BIT + 1;
   localparam logic [COUNTER_BIT:0] LastCnt = CntW'(LENGTH - 1);

   typedef enum logic [1:0] {StIdle, StMac, StDone} state_t;

   state_t               r_state;
   logic [COUNTER_BIT:0] r_cnt;
   logic                 w_in_ready;
   logic                 w_accept;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
         r_cnt   <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (bus.in_valid) begin
                  r_state <= StMac;
                  r_cnt   <= '0;
               end
            end
            StMac: begin
               if (r_cnt == LastCnt) begin
                  r_cnt   <= '0;
                  r_state <= StDone;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            StDone: begin
               if (bus.out_ready) r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Gated by reset so a sample can never be taken while the FSM is held in reset.
   assign w_in_ready = i_rst_n && (r_state == StIdle);
   assign w_accept   = w_in_ready && bus.in_valid;

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = (r_state == StDone);
   assign o_shift_en    = w_accept;
   assign o_flush       = w_accept;
   assign o_resreg_en   = (r_state == StMac);
   assign o_busy        = (r_state != StIdle);
   assign o_cnt         = r_cnt;

endmodule
